// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its
// optional "110" reference detector model (enabled by DETECT_MODEL_EN).
package serial_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_e;

    // Reference detector states: progress through the "110" pattern.
    typedef enum logic [1:0] {
        S0,
        S1,
        S11,
        S110
    } det_state_e;

    // Pattern the reference model recognises, first bit at index 2.
    localparam logic [2:0] DET_PATTERN = 3'b110;

endpackage

// File: rtl/serial_pattern_tx_seq110_model.sv
// Reference overlapping "110" Mealy detector. Advances only when en is high,
// returns to its start state on clr, and pulses hit combinationally on the
// bit that completes the pattern. Only instantiated with DETECT_MODEL_EN.
module seq110_model
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    det_state_e state_q;

    // Mealy output: the completing bit is seen while holding the "11" prefix.
    assign hit = en && (state_q == S11) && (bit_in == DET_PATTERN[0]);

    // Pattern tracking; a trailing 0 after "11" leaves no reusable prefix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
        end else if (clr) begin
            state_q <= S0;
        end else if (en) begin
            case (state_q)
                S0:      state_q <= bit_in ? S1  : S0;
                S1:      state_q <= bit_in ? S11 : S0;
                S11:     state_q <= bit_in ? S11 : S110;
                S110:    state_q <= bit_in ? S1  : S0;
                default: state_q <= S0;
            endcase
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial frame transmitter: accepts a word on a valid/ready
// handshake, shifts its low len bits out MSB-first on b/b_valid, inserts an
// idle gap and pulses done once per frame. Optional macro DETECT_MODEL_EN
// adds a "110" reference detector that counts expected detections.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int GAP_CYCLES = 1,
    localparam int LW         = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [LW-1:0]    tx_len,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             b,
    output logic             b_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       match_cnt
);

    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    tx_state_e        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [LW-1:0]    cnt_q;
    logic [LW-1:0]    eff_len_d;
    logic [GW-1:0]    gap_q;
    logic             b_q;
    logic             b_valid_q;
    logic             last_q;
    logic             done_q;
    logic             handshake;

    assign tx_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT) || (state_q == GAP);
    assign handshake = tx_valid && tx_ready;
    assign b         = b_q;
    assign b_valid   = b_valid_q;
    assign done      = done_q;

    // Clamp the requested length and left-align the frame so the first bit
    // to send sits in the top bit of the shift register.
    always_comb begin
        eff_len_d = tx_len;
        if ((tx_len == '0) || (tx_len > LW'(WIDTH))) begin
            eff_len_d = LW'(WIDTH);
        end
        shreg_d = tx_data << (LW'(WIDTH) - eff_len_d);
    end

    // Frame FSM with registered serial outputs; last_q marks the cycle the
    // final bit is on the wire so done lands on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            b_q       <= 1'b0;
            b_valid_q <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_q;
            last_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    b_q       <= 1'b0;
                    b_valid_q <= 1'b0;
                    if (tx_valid) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= eff_len_d;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    b_q       <= shreg_q[WIDTH-1];
                    b_valid_q <= 1'b1;
                    shreg_q   <= shreg_q << 1;
                    cnt_q     <= cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        last_q <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_q   <= GW'(GAP_CYCLES);
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    b_q       <= 1'b0;
                    b_valid_q <= 1'b0;
                    if (gap_q <= GW'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    b_q       <= 1'b0;
                    b_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DETECT_MODEL_EN
    logic       hit;
    logic [7:0] match_q;

    seq110_model u_model (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (handshake),
        .en     (b_valid_q),
        .bit_in (b_q),
        .hit    (hit)
    );

    // Saturating count of detections the downstream detector should report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 8'd0;
        end else if (hit && (match_q != 8'hFF)) begin
            match_q <= match_q + 8'd1;
        end
    end

    assign match_cnt = match_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign match_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with a one-cycle gap and
// one with no gap, sharing clock, reset and frame data.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] tx_data;
    logic [LW-1:0]    tx_len;
    logic             v1, v0;
    logic             rdy1, b1, bv1, busy1, done1;
    logic             rdy0, b0, bv0, busy0, done0;
    logic [7:0]       mc1, mc0;

    int checks = 0;
    int errors = 0;

    serial_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_len(tx_len),
        .tx_valid(v1), .tx_ready(rdy1), .b(b1), .b_valid(bv1),
        .busy(busy1), .done(done1), .match_cnt(mc1)
    );

    serial_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_len(tx_len),
        .tx_valid(v0), .tx_ready(rdy0), .b(b0), .b_valid(bv0),
        .busy(busy0), .done(done0), .match_cnt(mc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] pat;
    logic [3:0] fpat;

    initial begin
        rst_n   = 1'b0;
        tx_data = '0;
        tx_len  = '0;
        v1      = 1'b0;
        v0      = 1'b0;
        tick();
        // Reset state
        chk("rst_b", b1, 0);
        chk("rst_bvalid", bv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ready", rdy1, 1);
        chk("rst_match", mc1, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: full 8-bit frame 0xB6 with one gap cycle
        pat = 8'hB6; tx_data = pat; tx_len = 4'd8; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("t1_ready_lo", rdy1, 0);
        chk("t1_busy", busy1, 1);
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk("t1_bit", b1, pat[i]);
            chk("t1_bvalid", bv1, 1);
            chk("t1_done_lo", done1, 0);
        end
        chk("t1_busy_gap", busy1, 1);
        tick();
        chk("t1_done", done1, 1);
        chk("t1_bvalid_end", bv1, 0);
        chk("t1_b_end", b1, 0);
        tick();
        chk("t1_done_pulse", done1, 0);
        tick();
        chk("t1_ready", rdy1, 1);
        chk("t1_idle", busy1, 0);
        $display("frame t1 data=%02h len=8 sent", pat);

        // 2: three-bit frame "110"
        do_reset();
        tick();
        pat = 8'h06; tx_data = pat; tx_len = 4'd3; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("t2_bit", b1, pat[i]);
            chk("t2_bvalid", bv1, 1);
        end
        tick();
        chk("t2_bvalid_end", bv1, 0);
        chk("t2_done", done1, 1);
`ifdef DETECT_MODEL_EN
        chk("t2_match", mc1, 1);
`else
        chk("t2_match_off", mc1, 0);
`endif
        repeat (3) tick();
        $display("frame t2 data=%02h len=3 sent", pat);

        // 3: len=0 means full width; tx_valid held high while busy
        pat = 8'hA5; tx_data = pat; tx_len = 4'd0; v1 = 1'b1;
        tick();
        for (int i = 7; i >= 0; i--) begin
            tick();
            tx_data = 8'h00;
            chk("t3_bit", b1, pat[i]);
            chk("t3_bvalid", bv1, 1);
        end
        tick();
        v1 = 1'b0;
        chk("t3_done", done1, 1);
        chk("t3_ready", rdy1, 1);
        tick();
        chk("t3_no_extra_bv", bv1, 0);
        chk("t3_no_extra_ready", rdy1, 1);
        tick();
        chk("t3_no_extra_bv2", bv1, 0);
        $display("frame t3 data=%02h len=0 sent", pat);

        // 4: no gap, tx_valid held high, alternating data 1001/0110
        tx_len = 4'd4; tx_data = 8'h09; v0 = 1'b1;
        tick();
        tx_data = 8'h06;
        for (int f = 0; f < 3; f++) begin
            fpat = (f % 2 == 0) ? 4'h9 : 4'h6;
            for (int i = 3; i >= 0; i--) begin
                tick();
                chk("t4_bit", b0, fpat[i]);
                chk("t4_bvalid", bv0, 1);
                chk("t4_done_lo", done0, 0);
            end
            chk("t4_ready_last", rdy0, 1);
            if (f == 2) v0 = 1'b0;
            tick();
            tx_data = (f % 2 == 0) ? 8'h09 : 8'h06;
            chk("t4_gap_bv", bv0, 0);
            chk("t4_done", done0, 1);
            $display("frame t4.%0d data=%01h len=4 sent", f, fpat);
        end
        tick();
        chk("t4_done_once", done0, 0);
        chk("t4_stop_bv", bv0, 0);

        // 5: asynchronous reset during bit 4, then a clean frame
        tx_data = 8'hF0; tx_len = 4'd8; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (4) tick();
        chk("t5_bit4", b1, 1);
        chk("t5_bit4_valid", bv1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_b", b1, 0);
        chk("t5_async_bv", bv1, 0);
        chk("t5_async_busy", busy1, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("t5_no_done", done1, 0);
        tick();
        chk("t5_no_done2", done1, 0);
        pat = 8'h5A; tx_data = pat; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk("t5_bit", b1, pat[i]);
            chk("t5_bvalid", bv1, 1);
        end
        tick();
        chk("t5_done", done1, 1);
        $display("frame t5 data=%02h len=8 sent after abort", pat);

`ifdef DETECT_MODEL_EN
        // 6: 256 "110" frames saturate the detection count at 255
        do_reset();
        tx_data = 8'h06; tx_len = 4'd3;
        for (int n = 0; n < 256; n++) begin
            v1 = 1'b1;
            tick();
            v1 = 1'b0;
            repeat (4) tick();
            if (n == 253) chk("t6_count254", mc1, 254);
            if (n == 254) chk("t6_count255", mc1, 255);
        end
        chk("t6_saturate", mc1, 255);
        $display("frame t6 256 frames of 110 sent");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
